// File: rtl/matrix_mult_ctrl.sv
// Control FSM sequencing the Keccak rho/pi lane-index datapath through one walk of N_STEPS coordinates.
// Optional rho offset tracking is enabled by defining MATRIX_MULT_CTRL_ROT_OFS_EN.
module matrix_mult_ctrl #(
    parameter int N_STEPS = 24,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [4:0]       step_t,
    output logic [5:0]       rot_ofs,
    output logic [CNT_W-1:0] tLoopNum,
    output logic             ldRegUp,
    output logic             ldRegDn,
    output logic             selRegUp1,
    output logic             clrRegDn,
    output logic             cntMatrixClr,
    output logic             cntMatrixEn,
    output logic             cntMatrixLd,
    input  logic             cntMatrixCo
);

    // Preloading 2^CNT_W - N_STEPS makes the counter carry out on the last step.
    localparam logic [CNT_W-1:0] LOOP_NUM = CNT_W'(2**CNT_W - N_STEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_STEP,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic       xfer;
    logic [4:0] step_q, step_d;

    assign tLoopNum = LOOP_NUM;
    assign xfer     = (state_q == S_STEP) && idx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: state_d = S_STEP;
            S_STEP: if (xfer && cntMatrixCo) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_d = step_q;
        if (state_q == S_INIT) begin
            step_d = '0;
        end else if (xfer && !cntMatrixCo) begin
            step_d = step_q + 5'd1;
        end
    end

    assign step_t = step_q;

`ifdef MATRIX_MULT_CTRL_ROT_OFS_EN
    // Triangular-number offsets built incrementally: T(t+1) = T(t) + t + 2.
    logic [5:0] rot_q, rot_d;

    always_comb begin
        rot_d = rot_q;
        if (state_q == S_INIT) begin
            rot_d = 6'd1;
        end else if (xfer && !cntMatrixCo) begin
            rot_d = rot_q + {1'b0, step_q} + 6'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rot_q <= '0;
        else     rot_q <= rot_d;
    end

    assign rot_ofs = rot_q;
`else
    assign rot_ofs = '0;
`endif

    // Reset overrides the state decode so the datapath counter is cleared in the reset cycle.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        idx_valid    = 1'b0;
        ldRegUp      = 1'b0;
        ldRegDn      = 1'b0;
        selRegUp1    = 1'b0;
        clrRegDn     = 1'b0;
        cntMatrixClr = 1'b0;
        cntMatrixEn  = 1'b0;
        cntMatrixLd  = 1'b0;
        if (rst) begin
            cntMatrixClr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_INIT: begin
                    busy        = 1'b1;
                    cntMatrixLd = 1'b1;
                    ldRegUp     = 1'b1;
                    selRegUp1   = 1'b1;
                    clrRegDn    = 1'b1;
                end
                S_STEP: begin
                    busy      = 1'b1;
                    idx_valid = 1'b1;
                    if (idx_ready) begin
                        ldRegUp     = 1'b1;
                        ldRegDn     = 1'b1;
                        cntMatrixEn = 1'b1;
                    end
                end
                S_DONE: begin
                    busy         = 1'b1;
                    done         = 1'b1;
                    cntMatrixClr = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Self-checking bench for matrix_mult_ctrl: a 24-step instance and a 1-step instance,
// each closed around a behavioural stand-in for the lane-index datapath.
module tb_matrix_mult_ctrl;

    localparam int N = 24;
`ifdef MATRIX_MULT_CTRL_ROT_OFS_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    // {ldRegUp, ldRegDn, selRegUp1, clrRegDn, cntMatrixClr, cntMatrixEn, cntMatrixLd}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_INIT = 7'b1011001;
    localparam logic [6:0] C_XFER = 7'b1100010;
    localparam logic [6:0] C_CLR  = 7'b0000100;
    // {busy, done, idx_valid}
    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_INIT = 3'b100;
    localparam logic [2:0] S_STEP = 3'b101;
    localparam logic [2:0] S_DONE = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 24-step instance
    logic       start = 1'b0, idx_ready = 1'b0;
    logic       busy, done, idx_valid;
    logic [4:0] step_t, tLoopNum;
    logic [5:0] rot_ofs;
    logic       ldRegUp, ldRegDn, selRegUp1, clrRegDn, cntMatrixClr, cntMatrixEn, cntMatrixLd, cntMatrixCo;
    logic [6:0] ctrl;
    logic [2:0] stat;

    matrix_mult_ctrl #(.N_STEPS(N), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .step_t(step_t), .rot_ofs(rot_ofs),
        .tLoopNum(tLoopNum), .ldRegUp(ldRegUp), .ldRegDn(ldRegDn), .selRegUp1(selRegUp1),
        .clrRegDn(clrRegDn), .cntMatrixClr(cntMatrixClr), .cntMatrixEn(cntMatrixEn),
        .cntMatrixLd(cntMatrixLd), .cntMatrixCo(cntMatrixCo)
    );

    assign ctrl = {ldRegUp, ldRegDn, selRegUp1, clrRegDn, cntMatrixClr, cntMatrixEn, cntMatrixLd};
    assign stat = {busy, done, idx_valid};

    // 1-step instance
    logic       start_b = 1'b0, idx_ready_b = 1'b0;
    logic       busy_b, done_b, idx_valid_b;
    logic [4:0] step_t_b, tLoopNum_b;
    logic [5:0] rot_ofs_b;
    logic       ldRegUp_b, ldRegDn_b, selRegUp1_b, clrRegDn_b, cntMatrixClr_b, cntMatrixEn_b, cntMatrixLd_b, cntMatrixCo_b;
    logic [6:0] ctrl_b;
    logic [2:0] stat_b;

    matrix_mult_ctrl #(.N_STEPS(1), .CNT_W(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .idx_valid(idx_valid_b), .idx_ready(idx_ready_b), .step_t(step_t_b), .rot_ofs(rot_ofs_b),
        .tLoopNum(tLoopNum_b), .ldRegUp(ldRegUp_b), .ldRegDn(ldRegDn_b), .selRegUp1(selRegUp1_b),
        .clrRegDn(clrRegDn_b), .cntMatrixClr(cntMatrixClr_b), .cntMatrixEn(cntMatrixEn_b),
        .cntMatrixLd(cntMatrixLd_b), .cntMatrixCo(cntMatrixCo_b)
    );

    assign ctrl_b = {ldRegUp_b, ldRegDn_b, selRegUp1_b, clrRegDn_b, cntMatrixClr_b, cntMatrixEn_b, cntMatrixLd_b};
    assign stat_b = {busy_b, done_b, idx_valid_b};

    // Datapath stand-ins: up/down coordinate registers and the loadable loop counter.
    logic [4:0] cnt = '0, cnt_b = '0;
    logic [2:0] x = '0, y = '0, x_b = '0, y_b = '0;
    assign cntMatrixCo   = (cnt == 5'd31);
    assign cntMatrixCo_b = (cnt_b == 5'd31);

    always @(posedge clk) begin
        if (cntMatrixClr)     cnt <= '0;
        else if (cntMatrixLd) cnt <= tLoopNum;
        else if (cntMatrixEn) cnt <= cnt + 5'd1;
        if (ldRegUp)          x <= selRegUp1 ? 3'd1 : y;
        if (clrRegDn)         y <= '0;
        else if (ldRegDn)     y <= 3'((2 * x + 3 * y) % 5);

        if (cntMatrixClr_b)     cnt_b <= '0;
        else if (cntMatrixLd_b) cnt_b <= tLoopNum_b;
        else if (cntMatrixEn_b) cnt_b <= cnt_b + 5'd1;
        if (ldRegUp_b)          x_b <= selRegUp1_b ? 3'd1 : y_b;
        if (clrRegDn_b)         y_b <= '0;
        else if (ldRegDn_b)     y_b <= 3'((2 * x_b + 3 * y_b) % 5);
    end

    // Reference coordinate walk: (x,y) -> (y, 2x+3y mod 5) starting at (1,0).
    int ref_x[N];
    int ref_y[N];

    function automatic logic [5:0] exp_rot(input int t);
        int tri_n;
        tri_n = (t + 1) * (t + 2) / 2;
        return ROT_EN ? 6'(tri_n % 64) : 6'd0;
    endfunction

    task automatic build_ref();
        int cx, cy, nx;
        cx = 1;
        cy = 0;
        for (int i = 0; i < N; i++) begin
            ref_x[i] = cx;
            ref_y[i] = cy;
            nx = cy;
            cy = (2 * cx + 3 * cy) % 5;
            cx = nx;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        idx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (ctrl !== C_CLR) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_CLR);
        end
        n_cmp++;
        if (stat !== S_IDLE) begin
            n_bad++; $display("FAIL reset_status: got %b expected %b", stat, S_IDLE);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({stat, ctrl} !== {S_IDLE, C_NONE}) begin
            n_bad++; $display("FAIL idle_after_reset: got %b expected %b", {stat, ctrl}, {S_IDLE, C_NONE});
        end
        n_cmp++;
        if ({step_t, rot_ofs} !== 11'd0) begin
            n_bad++; $display("FAIL reset_step_rot: got step %0d rot %0d expected 0 0", step_t, rot_ofs);
        end
    endtask

    task automatic test_tloopnum();
        n_cmp++;
        if (tLoopNum !== 5'd8) begin
            n_bad++; $display("FAIL tloopnum: got %0d expected 8", tLoopNum);
        end
        n_cmp++;
        if (tLoopNum_b !== 5'd31) begin
            n_bad++; $display("FAIL tloopnum_n1: got %0d expected 31", tLoopNum_b);
        end
    endtask

    // One full walk. stall_at/stall_len force idx_ready low; rand_ready randomises it otherwise.
    task automatic run_walk(input string name, input int stall_at, input int stall_len,
                            input bit rand_ready, input bit keep_start, input bit skip_idle);
        int  k, stall_left;
        bit  ended;
        if (!skip_idle) begin
            @(negedge clk);
            start = 1'b1;
            idx_ready = 1'b1;
            #1;
            n_cmp++;
            if (stat !== S_IDLE) begin
                n_bad++; $display("FAIL %s_idle: got %b expected %b", name, stat, S_IDLE);
            end
        end
        @(negedge clk);
        start = keep_start;
        #1;
        n_cmp++;
        if ({stat, ctrl} !== {S_INIT, C_INIT}) begin
            n_bad++; $display("FAIL %s_init: got %b expected %b", name, {stat, ctrl}, {S_INIT, C_INIT});
        end
        k = 0;
        stall_left = stall_len;
        ended = 1'b0;
        for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
            @(negedge clk);
            if (k == stall_at && stall_left > 0) begin
                idx_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                idx_ready = 1'($urandom_range(0, 1));
            end else begin
                idx_ready = 1'b1;
            end
            #1;
            n_cmp++;
            if ({stat, step_t, x, y, rot_ofs} !== {S_STEP, 5'(k), 3'(ref_x[k]), 3'(ref_y[k]), exp_rot(k)}) begin
                n_bad++;
                $display("FAIL %s_step: got stat %b t %0d (x,y)=(%0d,%0d) rot %0d expected stat %b t %0d (x,y)=(%0d,%0d) rot %0d",
                         name, stat, step_t, x, y, rot_ofs, S_STEP, k, ref_x[k], ref_y[k], exp_rot(k));
            end
            n_cmp++;
            if (ctrl !== (idx_ready ? C_XFER : C_NONE)) begin
                n_bad++; $display("FAIL %s_ctrl t=%0d: got %b expected %b", name, k, ctrl, idx_ready ? C_XFER : C_NONE);
            end
            if (idx_ready) begin
                k++;
                if (k == N) ended = 1'b1;
            end
        end
        n_cmp++;
        if (!ended) begin
            n_bad++; $display("FAIL %s_timeout: got %0d transfers expected %0d", name, k, N);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({stat, ctrl} !== {S_DONE, C_CLR}) begin
            n_bad++; $display("FAIL %s_done: got %b expected %b", name, {stat, ctrl}, {S_DONE, C_CLR});
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({stat, ctrl} !== {S_IDLE, C_NONE}) begin
            n_bad++; $display("FAIL %s_after_done: got %b expected %b", name, {stat, ctrl}, {S_IDLE, C_NONE});
        end
    endtask

    task automatic test_walk();
        run_walk("walk", -1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_walk("stall", 2, 5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_ready();
        run_walk("rand", -1, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_walk("b2b_first", -1, 0, 1'b0, 1'b1, 1'b0);
        run_walk("b2b_second", -1, 0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_walk();
        @(negedge clk);
        start = 1'b1;
        idx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({stat, step_t} !== {S_STEP, 5'(k)}) begin
                n_bad++; $display("FAIL abort_walk t=%0d: got %b expected %b", k, {stat, step_t}, {S_STEP, 5'(k)});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({stat, ctrl} !== {S_IDLE, C_CLR}) begin
            n_bad++; $display("FAIL abort_rst_cycle: got %b expected %b", {stat, ctrl}, {S_IDLE, C_CLR});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({stat, ctrl, step_t, rot_ofs} !== {S_IDLE, C_NONE, 11'd0}) begin
            n_bad++;
            $display("FAIL abort_idle: got stat %b ctrl %b t %0d rot %0d expected stat %b ctrl %b t 0 rot 0",
                     stat, ctrl, step_t, rot_ofs, S_IDLE, C_NONE);
        end
        run_walk("after_abort", -1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_step();
        @(negedge clk);
        start_b = 1'b1;
        idx_ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        #1;
        n_cmp++;
        if ({stat_b, ctrl_b} !== {S_INIT, C_INIT}) begin
            n_bad++; $display("FAIL n1_init: got %b expected %b", {stat_b, ctrl_b}, {S_INIT, C_INIT});
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({stat_b, ctrl_b, step_t_b, x_b, y_b, rot_ofs_b} !== {S_STEP, C_XFER, 5'd0, 3'd1, 3'd0, exp_rot(0)}) begin
            n_bad++;
            $display("FAIL n1_step: got stat %b ctrl %b t %0d (x,y)=(%0d,%0d) rot %0d expected stat %b ctrl %b t 0 (1,0) rot %0d",
                     stat_b, ctrl_b, step_t_b, x_b, y_b, rot_ofs_b, S_STEP, C_XFER, exp_rot(0));
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({stat_b, ctrl_b} !== {S_DONE, C_CLR}) begin
            n_bad++; $display("FAIL n1_done: got %b expected %b", {stat_b, ctrl_b}, {S_DONE, C_CLR});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (stat_b !== S_IDLE) begin
            n_bad++; $display("FAIL n1_idle: got %b expected %b", stat_b, S_IDLE);
        end
        idx_ready_b = 1'b0;
    endtask

    initial begin
        build_ref();
        test_reset();
        test_tloopnum();
        test_walk();
        test_stall();
        test_random_ready();
        test_back_to_back();
        test_reset_mid_walk();
        test_single_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
